iob_dma_wdesc_ctrl: RTL
=======================

# iob_dma_wdesc_ctrl

Descriptor-queue controller that sequences the DMA write engine (`iob_dma_write`). Software or a upstream agent pushes (address, length) write descriptors into a small on-chip queue. The block issues them one at a time to the engine's `w_addr/w_length/w_start_transfer` port, waits for `w_busy` to drop, and reports completion. It sits between the DMA CSR/descriptor source and the write engine, in the same clock domain.

## Interface
Parameters:
- `AXI_ADDR_W`, 24, descriptor/engine byte address width
- `DMA_WLEN_W`, 12, descriptor length width in words
- `QUEUE_W`, 2, log2 of descriptor queue depth (depth = 2**QUEUE_W)
- `CNT_W`, 16, completion counter width

Ports:
- `clk_i` in 1: clock
- `cke_i` in 1: clock enable; all state holds when low
- `arst_i` in 1: reset, asynchronous, active-high
- `desc_valid_i` in 1: descriptor push request
- `desc_addr_i` in AXI_ADDR_W: descriptor start address
- `desc_len_i` in DMA_WLEN_W: descriptor length in words
- `desc_ready_o` out 1: queue accepts descriptor
- `abort_i` in 1: flush queue, one-cycle pulse
- `w_addr_o` out AXI_ADDR_W: to engine `w_addr_i`
- `w_length_o` out DMA_WLEN_W: to engine `w_length_i`
- `w_start_transfer_o` out 1: to engine, one-cycle start pulse
- `w_busy_i` in 1: from engine `w_busy_o`
- `done_o` out 1: one-cycle pulse per retired descriptor
- `done_cnt_o` out CNT_W: retired-descriptor count, wraps
- `level_o` out QUEUE_W+1: queued descriptors, excluding in-flight
- `busy_o` out 1: FSM not IDLE or queue non-empty

## Operation
- Push rules:
  - A descriptor is accepted when `desc_valid_i & desc_ready_o`.
  - `desc_ready_o = !full & state!=ABORT`.
  - A push when full is not possible, even with a simultaneous pop.
- FSM states: IDLE, ISSUE, RUN, ABORT.
- IDLE:
  - If the queue is non-empty and `w_busy_i==0`, pop the head into the `w_addr_o/w_length_o` registers and go to ISSUE.
  - If `w_busy_i==1`, stay in IDLE. This covers an engine still busy from a foreign start.
- ISSUE:
  - If length is non-zero, assert `w_start_transfer_o` for exactly this cycle and go to RUN.
  - If length is 0, issue no start, pulse `done_o`, increment the count, and return to IDLE.
- RUN:
  - Wait while `w_busy_i==1`.
  - In the first RUN cycle the engine is already busy (its state registers on the start cycle).
  - On `w_busy_i==0` in RUN: pulse `done_o`, increment `done_cnt_o`, and go to IDLE.
- ABORT:
  - Entered from any state on `abort_i`. `abort_i` has priority over a same-cycle push; that push is discarded.
  - The queue is cleared in the entry cycle.
  - If entered from RUN, the controller waits for `w_busy_i==0`, then pulses `done_o`, counts the in-flight descriptor, and goes to IDLE. The engine cannot be stopped mid-transfer.
  - From IDLE or ISSUE, the controller returns to IDLE next cycle.
  - An abort in ISSUE suppresses the start pulse.
  - Flushed descriptors are never counted.
- `done_cnt_o` wraps from 2**CNT_W-1 to 0.
- `level_o` ranges 0..2**QUEUE_W. Pointers are QUEUE_W+1 bits, and full/empty is decided by MSB compare.

## Timing
- Reset values: state=IDLE, queue empty, `desc_ready_o=1`, `w_addr_o=0`, `w_length_o=0`, `w_start_transfer_o=0`, `done_o=0`, `done_cnt_o=0`, `level_o=0`, `busy_o=0`.
- Issue latency: a push accepted in cycle N into an empty queue with the FSM in IDLE and the engine idle gives:
  - pop and ISSUE entry at N+1;
  - `w_start_transfer_o=1` at N+1 (Moore on ISSUE);
  - RUN at N+2.
- `w_addr_o/w_length_o` are stable from ISSUE until the next pop.
- Completion: `w_busy_i` falls in cycle M while in RUN, so `done_o=1` in cycle M+1 (registered). The next queued descriptor is popped at M+1 and started at M+2.
- Back-to-back descriptors have a minimum spacing of 3 cycles between start pulses plus the engine busy time.
- `busy_o` and `desc_ready_o` are combinational from registered state.

## Configuration
- `IOB_DMA_WDESC_CTRL_IRQ_EN`
  - Defined: adds `irq_en_i` (in 1), `irq_clr_i` (in 1) and `irq_o` (out 1, reset 0).
    - `irq_o` sets on a `done_o` pulse that leaves the queue empty with the FSM returning to IDLE, provided `irq_en_i=1`.
    - `irq_o` clears on `irq_clr_i`. Set wins over a same-cycle clear.
  - Undefined: those ports and the register do not exist.

## Structure
- Shared header `iob_dma_wdesc_ctrl_pkg.vh` holds:
  - state encodings `WDESC_IDLE=2'd0`, `WDESC_ISSUE=2'd1`, `WDESC_RUN=2'd2`, `WDESC_ABORT=2'd3`;
  - the descriptor width localparam `DESC_W = AXI_ADDR_W+DMA_WLEN_W`.
- One sub-module: `iob_dma_wdesc_fifo`, a register-based {addr,len} FIFO of depth 2**QUEUE_W with push, pop, flush, level, full and empty.
- All registers use `iob_reg_r`-style cke/async reset.

## Test plan
- Single descriptor (0x000100, len 16) pushed while idle:
  - start pulse 1 cycle after accept with `w_addr_o=0x000100` and `w_length_o=16`;
  - engine model holds busy 20 cycles; `done_o` one cycle after busy falls; `done_cnt_o=1`.
- Push 5 descriptors back-to-back with QUEUE_W=2:
  - `desc_ready_o` drops after 4 are queued;
  - all 5 are issued in order, with start pulses ≥3 cycles apart;
  - `done_cnt_o=5` and `level_o=0` at end.
- Zero-length descriptor between two len-8 descriptors:
  - only 2 start pulses; 3 done pulses; `done_cnt_o=3`.
- `abort_i` during RUN with 3 descriptors queued:
  - `level_o=0` next cycle; no further starts;
  - one `done_o` after busy falls; `done_cnt_o` increases by 1.
- Assert `arst_i` mid-RUN: all outputs return to reset values immediately. Counter wrap with CNT_W=2: 5 completions give `done_cnt_o=1`.
- With IRQ_EN defined and `irq_en_i=1`:
  - `irq_o` rises with the last `done_o` of a 2-descriptor batch, and not on the first;
  - `irq_clr_i` clears it;
  - simultaneous set and clear leaves `irq_o=1`.

Source files
------------

// File: rtl/iob_dma_wdesc_ctrl_pkg.sv
// iob_dma_wdesc_ctrl_pkg
// Shared definitions for the DMA write-descriptor controller:
//   - FSM state encodings (WDESC_IDLE/ISSUE/RUN/ABORT)
//   - desc_w(): width of a packed {addr,len} descriptor
package iob_dma_wdesc_ctrl_pkg;

    localparam logic [1:0] WDESC_IDLE  = 2'd0;
    localparam logic [1:0] WDESC_ISSUE = 2'd1;
    localparam logic [1:0] WDESC_RUN   = 2'd2;
    localparam logic [1:0] WDESC_ABORT = 2'd3;

    // Descriptor word is {addr, len}; DESC_W = AXI_ADDR_W + DMA_WLEN_W.
    function automatic int desc_w(input int addr_w, input int len_w);
        return addr_w + len_w;
    endfunction

endpackage

// File: rtl/iob_dma_wdesc_fifo.sv
// iob_dma_wdesc_fifo
// Register-based descriptor FIFO, depth 2**QUEUE_W.
// Ports:
//   clk_i, cke_i, arst_i      : clock, clock enable, async active-high reset
//   push_i / push_data_i      : write request and descriptor (ignored when full)
//   pop_i                     : advance head (ignored when empty)
//   flush_i                   : drop all entries; overrides push and pop
//   pop_data_o                : current head entry
//   level_o, full_o, empty_o  : occupancy status
module iob_dma_wdesc_fifo #(
    parameter int DATA_W  = 36,
    parameter int QUEUE_W = 2
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               arst_i,
    input  logic               push_i,
    input  logic [DATA_W-1:0]  push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [DATA_W-1:0]  pop_data_o,
    output logic [QUEUE_W:0]   level_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int DEPTH = 2 ** QUEUE_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [QUEUE_W:0]  wr_ptr_reg, wr_ptr_next;
    logic [QUEUE_W:0]  rd_ptr_reg, rd_ptr_next;
    logic              push_en;
    logic              pop_en;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[QUEUE_W] != rd_ptr_reg[QUEUE_W]) &&
                     (wr_ptr_reg[QUEUE_W-1:0] == rd_ptr_reg[QUEUE_W-1:0]);
    assign level_o = wr_ptr_reg - rd_ptr_reg;

    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    assign pop_data_o = mem_reg[rd_ptr_reg[QUEUE_W-1:0]];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push_en) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (cke_i) begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    mem_reg[gi] <= '0;
                end else if (cke_i && push_en &&
                             (wr_ptr_reg[QUEUE_W-1:0] == QUEUE_W'(gi))) begin
                    mem_reg[gi] <= push_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/iob_dma_wdesc_ctrl.sv
// iob_dma_wdesc_ctrl
// Queues (address, length) write descriptors and issues them one at a time
// to the DMA write engine, reporting each completion.
// Ports:
//   clk_i, cke_i, arst_i                  : clock, clock enable, async reset
//   desc_valid_i/addr_i/len_i, desc_ready_o : descriptor push handshake
//   abort_i                               : flush queue (one-cycle pulse)
//   w_addr_o, w_length_o, w_start_transfer_o, w_busy_i : engine interface
//   done_o, done_cnt_o                    : completion pulse and wrapping count
//   level_o, busy_o                       : queue occupancy, activity flag
// Optional feature: define IOB_DMA_WDESC_CTRL_IRQ_EN to add irq_en_i,
// irq_clr_i and irq_o (batch-complete interrupt).
module iob_dma_wdesc_ctrl
    import iob_dma_wdesc_ctrl_pkg::*;
#(
    parameter int AXI_ADDR_W = 24,
    parameter int DMA_WLEN_W = 12,
    parameter int QUEUE_W    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  desc_valid_i,
    input  logic [AXI_ADDR_W-1:0] desc_addr_i,
    input  logic [DMA_WLEN_W-1:0] desc_len_i,
    output logic                  desc_ready_o,
    input  logic                  abort_i,
    output logic [AXI_ADDR_W-1:0] w_addr_o,
    output logic [DMA_WLEN_W-1:0] w_length_o,
    output logic                  w_start_transfer_o,
    input  logic                  w_busy_i,
    output logic                  done_o,
    output logic [CNT_W-1:0]      done_cnt_o,
    output logic [QUEUE_W:0]      level_o,
`ifdef IOB_DMA_WDESC_CTRL_IRQ_EN
    input  logic                  irq_en_i,
    input  logic                  irq_clr_i,
    output logic                  irq_o,
`endif
    output logic                  busy_o
);

    localparam int DESC_W = desc_w(AXI_ADDR_W, DMA_WLEN_W);

    logic [1:0]            state_reg, state_next;
    logic [AXI_ADDR_W-1:0] w_addr_reg, w_addr_next;
    logic [DMA_WLEN_W-1:0] w_length_reg, w_length_next;
    logic                  done_reg, done_next;
    logic [CNT_W-1:0]      done_cnt_reg, done_cnt_next;
    logic                  inflight_reg, inflight_next;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic [DESC_W-1:0]     head_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_acc;

    iob_dma_wdesc_fifo #(
        .DATA_W  (DESC_W),
        .QUEUE_W (QUEUE_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .arst_i      (arst_i),
        .push_i      (fifo_push),
        .push_data_i ({desc_addr_i, desc_len_i}),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .pop_data_o  (head_data),
        .level_o     (level_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign desc_ready_o = !fifo_full && (state_reg != WDESC_ABORT);
    // Abort wins over a same-cycle push: that descriptor is dropped.
    assign push_acc     = desc_valid_i && desc_ready_o && !abort_i;
    assign busy_o       = (state_reg != WDESC_IDLE) || !fifo_empty;

    // Start is Moore on ISSUE; an abort landing in ISSUE cancels it.
    assign w_start_transfer_o = (state_reg == WDESC_ISSUE) &&
                                (w_length_reg != '0) && !abort_i;
    assign w_addr_o   = w_addr_reg;
    assign w_length_o = w_length_reg;
    assign done_o     = done_reg;
    assign done_cnt_o = done_cnt_reg;

    always_comb begin
        state_next    = state_reg;
        w_addr_next   = w_addr_reg;
        w_length_next = w_length_reg;
        done_next     = 1'b0;
        done_cnt_next = done_cnt_reg;
        inflight_next = inflight_reg;
        fifo_push     = push_acc;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;

        if (abort_i) begin
            state_next    = WDESC_ABORT;
            fifo_flush    = 1'b1;
            // Remember whether a started transfer must still be waited out.
            inflight_next = (state_reg == WDESC_RUN) ||
                            ((state_reg == WDESC_ABORT) && inflight_reg);
        end else begin
            case (state_reg)
                WDESC_IDLE: begin
                    if (!w_busy_i) begin
                        if (!fifo_empty) begin
                            fifo_pop      = 1'b1;
                            w_addr_next   = head_data[DESC_W-1:DMA_WLEN_W];
                            w_length_next = head_data[DMA_WLEN_W-1:0];
                            state_next    = WDESC_ISSUE;
                        end else if (push_acc) begin
                            // Empty queue: take the incoming descriptor straight
                            // to the issue registers so it starts next cycle.
                            fifo_push     = 1'b0;
                            w_addr_next   = desc_addr_i;
                            w_length_next = desc_len_i;
                            state_next    = WDESC_ISSUE;
                        end
                    end
                end
                WDESC_ISSUE: begin
                    if (w_length_reg != '0) begin
                        state_next = WDESC_RUN;
                    end else begin
                        done_next     = 1'b1;
                        done_cnt_next = done_cnt_reg + 1'b1;
                        state_next    = WDESC_IDLE;
                    end
                end
                WDESC_RUN: begin
                    if (!w_busy_i) begin
                        done_next     = 1'b1;
                        done_cnt_next = done_cnt_reg + 1'b1;
                        state_next    = WDESC_IDLE;
                    end
                end
                default: begin
                    if (!inflight_reg) begin
                        state_next = WDESC_IDLE;
                    end else if (!w_busy_i) begin
                        done_next     = 1'b1;
                        done_cnt_next = done_cnt_reg + 1'b1;
                        inflight_next = 1'b0;
                        state_next    = WDESC_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg    <= WDESC_IDLE;
            w_addr_reg   <= '0;
            w_length_reg <= '0;
            done_reg     <= 1'b0;
            done_cnt_reg <= '0;
            inflight_reg <= 1'b0;
        end else if (cke_i) begin
            state_reg    <= state_next;
            w_addr_reg   <= w_addr_next;
            w_length_reg <= w_length_next;
            done_reg     <= done_next;
            done_cnt_reg <= done_cnt_next;
            inflight_reg <= inflight_next;
        end
    end

`ifdef IOB_DMA_WDESC_CTRL_IRQ_EN
    logic irq_reg, irq_next;
    logic irq_set;

    // Batch complete: this completion returns to IDLE with nothing left queued.
    assign irq_set = done_next && (state_next == WDESC_IDLE) &&
                     fifo_empty && !fifo_push && irq_en_i;

    always_comb begin
        irq_next = irq_reg;
        if (irq_set)        irq_next = 1'b1;
        else if (irq_clr_i) irq_next = 1'b0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)     irq_reg <= 1'b0;
        else if (cke_i) irq_reg <= irq_next;
    end

    assign irq_o = irq_reg;
`endif

endmodule
